// File: rtl/reset_seq_pkg.sv
// Shared types and helpers for the reset sequencer.
// The state encoding is visible on state_dbg, so the values are pinned explicitly.
package reset_seq_pkg;

  typedef enum logic [2:0] {
    WAIT_LOCK = 3'd0,
    POR       = 3'd1,
    RELEASE   = 3'd2,
    RUN       = 3'd3,
    HOLD      = 3'd4
  } state_t;

  function automatic int max3(input int a, input int b, input int c);
    int m;
    m = (a > b) ? a : b;
    return (m > c) ? m : c;
  endfunction

endpackage

// File: rtl/reset_sync_bit.sv
// Multi-flop synchroniser for a single asynchronous level.
// It is cleared by the async reset, so the output reads 0 until the chain has refilled.
module reset_sync_bit #(
  parameter int SYNC_STAGES = 2
) (
  input  logic sys_clk,
  input  logic reset_n,
  input  logic d,
  output logic q
);

  logic [SYNC_STAGES-1:0] sync_reg;

  always_ff @(posedge sys_clk or negedge reset_n) begin
    if (!reset_n) begin
      sync_reg <= '0;
    end else begin
      sync_reg <= {sync_reg[SYNC_STAGES-2:0], d};
    end
  end

  assign q = sync_reg[SYNC_STAGES-1];

endmodule

// File: rtl/reset_sequencer.sv
// Power-on / soft-reset sequencer: waits for PLL lock, holds POR, then releases
// the channel resets one by one, lowest index first.
module reset_sequencer
  import reset_seq_pkg::*;
#(
  parameter int NUM_CHANNELS      = 3,
  parameter int POR_CYCLES        = 100,
  parameter int STAGE_CYCLES      = 100,
  parameter int SOFT_RESET_CYCLES = 16,
  parameter int SYNC_STAGES       = 2
) (
  input  logic                    sys_clk,
  input  logic                    reset_n,
  input  logic                    pll_locked,
  input  logic                    soft_reset_req,
  output logic [NUM_CHANNELS-1:0] reset_out,
  output logic                    all_released,
  output logic                    busy,
  output logic [2:0]              state_dbg
);

  localparam int CNT_W = $clog2(max3(POR_CYCLES, STAGE_CYCLES, SOFT_RESET_CYCLES) + 1);
  localparam int IDX_W = $clog2(NUM_CHANNELS + 1);

  localparam logic [CNT_W-1:0] POR_LAST   = CNT_W'(POR_CYCLES - 1);
  localparam logic [CNT_W-1:0] STAGE_LAST = CNT_W'(STAGE_CYCLES - 1);
  localparam logic [CNT_W-1:0] SOFT_LAST  = CNT_W'(SOFT_RESET_CYCLES - 1);
  localparam logic [IDX_W-1:0] IDX_LAST   = IDX_W'(NUM_CHANNELS - 1);

  state_t                  state_reg;
  logic [CNT_W-1:0]        cnt_reg;
  logic [IDX_W-1:0]        idx_reg;
  logic [NUM_CHANNELS-1:0] reset_out_reg;
  logic                    all_released_reg;
  logic                    busy_reg;
  logic                    locked_sync;

  reset_sync_bit #(
    .SYNC_STAGES(SYNC_STAGES)
  ) u_lock_sync (
    .sys_clk (sys_clk),
    .reset_n (reset_n),
    .d       (pll_locked),
    .q       (locked_sync)
  );

  // Channels release strictly in order, so releasing channel idx is the same
  // as shifting one more zero in from the bottom of the vector.
  always_ff @(posedge sys_clk or negedge reset_n) begin
    if (!reset_n) begin
      state_reg        <= WAIT_LOCK;
      cnt_reg          <= '0;
      idx_reg          <= '0;
      reset_out_reg    <= '1;
      all_released_reg <= 1'b0;
      busy_reg         <= 1'b1;
    end else if (state_reg != WAIT_LOCK && !locked_sync) begin
      state_reg        <= WAIT_LOCK;
      cnt_reg          <= '0;
      idx_reg          <= '0;
      reset_out_reg    <= '1;
      all_released_reg <= 1'b0;
      busy_reg         <= 1'b1;
    end else begin
      case (state_reg)
        WAIT_LOCK: begin
          if (locked_sync) begin
            state_reg <= POR;
            cnt_reg   <= '0;
          end
        end
        POR: begin
          if (cnt_reg == POR_LAST) begin
            cnt_reg       <= '0;
            idx_reg       <= IDX_W'(1);
            reset_out_reg <= reset_out_reg << 1;
            if (NUM_CHANNELS == 1) begin
              state_reg        <= RUN;
              all_released_reg <= 1'b1;
              busy_reg         <= 1'b0;
            end else begin
              state_reg <= RELEASE;
            end
          end else begin
            cnt_reg <= cnt_reg + 1'b1;
          end
        end
        RELEASE: begin
          if (cnt_reg == STAGE_LAST) begin
            cnt_reg       <= '0;
            idx_reg       <= idx_reg + 1'b1;
            reset_out_reg <= reset_out_reg << 1;
            if (idx_reg == IDX_LAST) begin
              state_reg        <= RUN;
              all_released_reg <= 1'b1;
              busy_reg         <= 1'b0;
            end
          end else begin
            cnt_reg <= cnt_reg + 1'b1;
          end
        end
        RUN: begin
          if (soft_reset_req) begin
            state_reg        <= HOLD;
            cnt_reg          <= '0;
            reset_out_reg    <= '1;
            all_released_reg <= 1'b0;
            busy_reg         <= 1'b1;
          end
        end
        HOLD: begin
          if (cnt_reg == SOFT_LAST) begin
            state_reg <= WAIT_LOCK;
            cnt_reg   <= '0;
          end else begin
            cnt_reg <= cnt_reg + 1'b1;
          end
        end
        default: begin
          state_reg        <= WAIT_LOCK;
          cnt_reg          <= '0;
          idx_reg          <= '0;
          reset_out_reg    <= '1;
          all_released_reg <= 1'b0;
          busy_reg         <= 1'b1;
        end
      endcase
    end
  end

  assign reset_out    = reset_out_reg;
  assign all_released = all_released_reg;
  assign busy         = busy_reg;
  assign state_dbg    = state_reg;

endmodule

// File: tb/tb_reset_sequencer.sv
// Scoreboard bench: release schedules are computed from lock/soft/abort times and
// compared against every observed output change of a 3-channel and a 1-channel build.
module tb_reset_sequencer;

  localparam int NCH   = 3;
  localparam int POR   = 4;
  localparam int STAGE = 3;
  localparam int SOFT  = 5;
  localparam int SYNC  = 2;

  typedef struct packed {
    int         edge_n;
    logic [4:0] val;
  } exp_t;

  logic           sys_clk;
  logic           reset_n;
  logic           pll_locked;
  logic           soft0;
  logic           soft1;
  logic [NCH-1:0] ro0;
  logic           ar0;
  logic           busy0;
  logic [2:0]     st0;
  logic [0:0]     ro1;
  logic           ar1;
  logic           busy1;
  logic [2:0]     st1;

  exp_t       q0[$];
  exp_t       q1[$];
  logic [4:0] prev_obs[2];
  logic [4:0] model_cur[2];
  int         checks = 0;
  int         errors = 0;
  int         edge_cnt = 0;
  bit         started = 1'b0;
  bit         mon_en = 1'b0;

  reset_sequencer #(
    .NUM_CHANNELS(NCH), .POR_CYCLES(POR), .STAGE_CYCLES(STAGE),
    .SOFT_RESET_CYCLES(SOFT), .SYNC_STAGES(SYNC)
  ) dut0 (
    .sys_clk(sys_clk), .reset_n(reset_n), .pll_locked(pll_locked),
    .soft_reset_req(soft0), .reset_out(ro0), .all_released(ar0),
    .busy(busy0), .state_dbg(st0)
  );

  reset_sequencer #(
    .NUM_CHANNELS(1), .POR_CYCLES(POR), .STAGE_CYCLES(STAGE),
    .SOFT_RESET_CYCLES(SOFT), .SYNC_STAGES(SYNC)
  ) dut1 (
    .sys_clk(sys_clk), .reset_n(reset_n), .pll_locked(pll_locked),
    .soft_reset_req(soft1), .reset_out(ro1), .all_released(ar1),
    .busy(busy1), .state_dbg(st1)
  );

  initial begin
    sys_clk = 1'b0;
    forever #5 sys_clk = ~sys_clk;
  end

  always @(posedge sys_clk) begin
    if (started) edge_cnt <= edge_cnt + 1;
  end

  // ---------------- reference model ----------------
  function automatic int nch_of(input int d);
    return (d == 0) ? NCH : 1;
  endfunction

  function automatic logic [2:0] full_of(input int d);
    return 3'((1 << nch_of(d)) - 1);
  endfunction

  function automatic logic [4:0] rst_val(input int d);
    return {full_of(d), 1'b0, 1'b1};
  endfunction

  function automatic logic [4:0] rel_val(input int d, input int k);
    logic [2:0] ro;
    logic       last;
    ro   = full_of(d) & ~3'((2 << k) - 1);
    last = (k == nch_of(d) - 1);
    return {ro, last, ~last};
  endfunction

  function automatic logic [4:0] obs(input int d);
    return (d == 0) ? {ro0, ar0, busy0} : {2'b00, ro1, ar1, busy1};
  endfunction

  function automatic logic [4:0] last_val(input int d);
    if (d == 0) return (q0.size() > 0) ? q0[q0.size()-1].val : model_cur[0];
    return (q1.size() > 0) ? q1[q1.size()-1].val : model_cur[1];
  endfunction

  function automatic int last_edge0();
    return (q0.size() > 0) ? q0[q0.size()-1].edge_n : -1;
  endfunction

  task automatic push(input int d, input int e, input logic [4:0] v);
    exp_t x;
    x.edge_n = e;
    x.val    = v;
    if (d == 0) q0.push_back(x);
    else        q1.push_back(x);
  endtask

  task automatic truncate(input int d, input int from_edge);
    if (d == 0) begin
      while (q0.size() > 0 && q0[q0.size()-1].edge_n >= from_edge) void'(q0.pop_back());
    end else begin
      while (q1.size() > 0 && q1[q1.size()-1].edge_n >= from_edge) void'(q1.pop_back());
    end
  endtask

  // All channels forced back into reset at edge e; anything planned from e on is void.
  task automatic reset_to(input int d, input int e);
    truncate(d, e);
    if (last_val(d) != rst_val(d)) push(d, e, rst_val(d));
  endtask

  // Channel k leaves reset k*STAGE edges after channel 0, which leaves at base.
  task automatic sched(input int d, input int base);
    for (int k = 0; k < nch_of(d); k++) push(d, base + k * STAGE, rel_val(d, k));
  endtask

  // ---------------- monitor ----------------
  task automatic mon_check(input int d);
    logic [4:0] cur;
    exp_t       e;
    bit         have;
    cur  = obs(d);
    have = 1'b0;
    e    = '0;
    if (cur !== prev_obs[d]) begin
      if (d == 0 && q0.size() > 0) begin e = q0.pop_front(); have = 1'b1; end
      if (d == 1 && q1.size() > 0) begin e = q1.pop_front(); have = 1'b1; end
      checks++;
      if (!have) begin
        errors++;
        $display("FAIL unexpected_change dut%0d edge %0d got %b required no change", d, edge_cnt, cur);
      end else begin
        model_cur[d] = e.val;
        if (e.edge_n != edge_cnt || e.val !== cur) begin
          errors++;
          $display("FAIL transition dut%0d got %b at edge %0d required %b at edge %0d",
                   d, cur, edge_cnt, e.val, e.edge_n);
        end else begin
          $display("tx dut%0d edge %0d reset_out/all_released/busy = %b", d, edge_cnt, cur);
        end
      end
      prev_obs[d] = cur;
    end
  endtask

  task automatic mon_loop();
    forever begin
      @(negedge sys_clk);
      if (mon_en) begin
        mon_check(0);
        mon_check(1);
      end
    end
  endtask

  // ---------------- stimulus helpers ----------------
  task automatic tick();
    @(negedge sys_clk);
    #1;
  endtask

  task automatic chk(input string name, input logic [7:0] got, input logic [7:0] req);
    checks++;
    if (got !== req) begin
      errors++;
      $display("FAIL %s got %0h required %0h", name, got, req);
    end else begin
      $display("tx check %s = %0h", name, got);
    end
  endtask

  task automatic chk_reset_outputs(input string tag);
    chk({tag, "_ro0"},    {5'b0, ro0}, 8'h07);
    chk({tag, "_ar0"},    {7'b0, ar0}, 8'h00);
    chk({tag, "_busy0"},  {7'b0, busy0}, 8'h01);
    chk({tag, "_state0"}, {5'b0, st0}, 8'h00);
    chk({tag, "_ro1"},    {7'b0, ro1}, 8'h01);
    chk({tag, "_busy1"},  {7'b0, busy1}, 8'h01);
    chk({tag, "_state1"}, {5'b0, st1}, 8'h00);
  endtask

  task automatic wait_run(input string name);
    int n;
    n = 0;
    while ((q0.size() != 0 || q1.size() != 0) && n < 400) begin
      tick();
      n++;
    end
    checks++;
    if (q0.size() != 0 || q1.size() != 0) begin
      errors++;
      $display("FAIL %s_timeout pending %0d/%0d required 0/0", name, q0.size(), q1.size());
      q0.delete();
      q1.delete();
    end
  endtask

  task automatic chk_run(input string tag);
    chk({tag, "_state0"}, {5'b0, st0}, 8'h03);
    chk({tag, "_state1"}, {5'b0, st1}, 8'h03);
  endtask

  // Caller guarantees both builds are in RUN.
  task automatic do_soft(output int rel0);
    int ts;
    tick();
    soft0 = 1'b1;
    soft1 = 1'b1;
    ts = edge_cnt + 1;
    for (int d = 0; d < 2; d++) begin
      reset_to(d, ts);
      sched(d, ts + SOFT + 1 + POR);
    end
    rel0 = ts + SOFT + 1 + POR;
    tick();
    soft1 = 1'b0;
    chk("hold_state0", {5'b0, st0}, 8'h04);
    chk("hold_state1", {5'b0, st1}, 8'h04);
    // A repeat request inside HOLD must not stretch the hold window.
    soft0 = 1'b1;
    tick();
    soft0 = 1'b0;
  endtask

  task automatic do_lockloss(input int hold, output int tl2);
    int tl;
    tick();
    pll_locked = 1'b0;
    tl = edge_cnt + 1;
    reset_to(0, tl + SYNC);
    reset_to(1, tl + SYNC);
    repeat (hold) tick();
    if (hold >= SYNC + 1) begin
      chk("nolock_state0", {5'b0, st0}, 8'h00);
      chk("nolock_ro0",    {5'b0, ro0}, 8'h07);
      chk("nolock_state1", {5'b0, st1}, 8'h00);
    end
    pll_locked = 1'b1;
    tl2 = edge_cnt + 1;
    sched(0, tl2 + SYNC + POR);
    sched(1, tl2 + SYNC + POR);
  endtask

  task automatic do_abort();
    int e;
    tick();
    reset_n = 1'b0;
    #1;
    chk_reset_outputs("abort");
    #1;
    reset_n = 1'b1;
    e = edge_cnt + 1;
    for (int d = 0; d < 2; d++) begin
      reset_to(d, e);
      sched(d, e + SYNC + POR);
    end
  endtask

  // ---------------- main sequence ----------------
  initial begin
    int rel0;
    int tl2;
    int n;
    reset_n     = 1'b0;
    pll_locked  = 1'b1;
    soft0       = 1'b0;
    soft1       = 1'b0;
    prev_obs[0] = rst_val(0);
    prev_obs[1] = rst_val(1);
    model_cur[0] = rst_val(0);
    model_cur[1] = rst_val(1);
    fork
      mon_loop();
      begin
        #2000000;
        $display("FAIL watchdog expired at edge %0d", edge_cnt);
        $fatal(1, "watchdog");
      end
    join_none

    #12;
    chk_reset_outputs("por");

    // Power-up with lock already present: edges 7/10/13, single channel at 7.
    tick();
    reset_n = 1'b1;
    started = 1'b1;
    mon_en  = 1'b1;
    sched(0, 1 + SYNC + POR);
    sched(1, 1 + SYNC + POR);
    wait_run("powerup");
    chk_run("powerup");

    do_soft(rel0);
    wait_run("soft");
    chk_run("soft");

    // Drop lock once channel 0 is out again, then keep it low for 50 cycles.
    do_soft(rel0);
    while (edge_cnt < rel0) tick();
    do_lockloss(50, tl2);

    // Abort asynchronously while POR is counting.
    while (edge_cnt < tl2 + SYNC + 1) tick();
    chk("por_state0", {5'b0, st0}, 8'h01);
    do_abort();
    wait_run("abort");
    chk_run("abort");

    for (int it = 0; it < 30; it++) begin
      case ($urandom_range(0, 3))
        0: begin
          n = $urandom_range(1, 40);
          repeat (n) begin
            soft0 = (q0.size() > 0 && last_edge0() > edge_cnt + 1 && $urandom_range(0, 2) == 0);
            tick();
          end
          soft0 = 1'b0;
        end
        1: begin
          wait_run("rand_soft");
          do_soft(rel0);
        end
        2: begin
          do_lockloss($urandom_range(1, 20), tl2);
        end
        default: begin
          n = $urandom_range(0, 25);
          repeat (n) tick();
          do_abort();
        end
      endcase
    end
    wait_run("final");
    chk_run("final");

    $display("CHECKS %0d ERRORS %0d", checks, errors);
    $finish;
  end

endmodule
